seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//   Iterative radix-2 restoring unsigned divider; inverse companion of the pipelined
//   Multiplier in the arithmetic library. Accepts dividend/divisor over valid/ready,
//   produces one quotient bit per clock, returns quotient/remainder over valid/ready.
//   Non-pipelined: one operation in flight; used where area matters more than throughput.
// PARAMETERS
//   WIDTH_N  10  dividend and quotient width (bits)
//   WIDTH_D  6   divisor and remainder width (bits)
// PORTS
//   clk          in   1        rising-edge clock
//   rst_n        in   1        asynchronous active-low reset
//   in_valid     in   1        operand request valid
//   in_ready     out  1        divider can accept operands (high only in IDLE)
//   dividend     in   WIDTH_N  unsigned dividend, sampled on in_valid&&in_ready
//   divisor      in   WIDTH_D  unsigned divisor, sampled with dividend
//   out_valid    out  1        result valid
//   out_ready    in   1        consumer accepts result
//   quotient     out  WIDTH_N  unsigned quotient
//   remainder    out  WIDTH_D  unsigned remainder
//   div_by_zero  out  1        result came from divisor==0
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE, out_valid=0, quotient=0, remainder=0,
//     div_by_zero=0, iteration count=0; in_ready=1 once in IDLE. Mid-operation reset aborts
//     the operation; no result is ever delivered for it.
//   States: IDLE -> BUSY -> DONE -> IDLE; IDLE -> DONE directly for divide-by-zero.
//   IDLE: in_ready=1. On edge E0 with in_valid: capture operands.
//     divisor!=0: load shift reg with dividend, partial remainder (WIDTH_D+1 bits)=0,
//       count=WIDTH_N, go BUSY.
//     divisor==0: quotient={WIDTH_N{1'b1}}, remainder=dividend[WIDTH_D-1:0],
//       div_by_zero=1, go DONE; out_valid high after edge E0+1 is not used, i.e. visible
//       the cycle right after E0.
//   BUSY: in_ready=0. Each edge: pr={pr[WIDTH_D-1:0],msb of shift reg}; if pr>=divisor,
//     pr-=divisor and shift in quotient bit 1, else shift in 0; count-=1. After the
//     WIDTH_N-th iteration (edge E0+WIDTH_N) load quotient/remainder, div_by_zero=0,
//     go DONE. out_valid first high in the cycle after edge E0+WIDTH_N.
//   DONE: out_valid=1, in_ready=0; in_valid ignored (not sampled, no queuing).
//     quotient/remainder/div_by_zero held stable while out_valid&&!out_ready.
//     On out_valid&&out_ready edge: out_valid=0, go IDLE; result outputs keep their
//     values until the next completion overwrites them.
//   Throughput: at most one operation per WIDTH_N+2 cycles (accept, iterate, handshake).
//   Invariant: for divisor!=0, dividend == quotient*divisor + remainder, remainder<divisor.
//   Partial remainder never exceeds WIDTH_D+1 bits; remainder output is its low WIDTH_D bits.
// TESTING
//   1. 100/7 (defaults), out_ready=1 -> after 10 edges out_valid=1, q=14, r=2, dbz=0.
//   2. 1023/1 and 5/63 -> q=1023 r=0; q=0 r=5; latency 10 edges each.
//   3. 500/0 -> out_valid the cycle after accept, q=1023, r=52, dbz=1; next op 9/3 q=3 r=0 dbz=0.
//   4. Backpressure: 100/7 with out_ready=0 for 5 cycles -> q=14,r=2 stable, in_ready=0,
//      in_valid pulses with other operands ignored; release -> IDLE, in_ready=1 next cycle.
//   5. Reset mid-op: rst_n low after 4 BUSY edges -> out_valid=0 immediately, no result;
//      after release 77/6 -> q=12, r=5.
//   6. Random sweep 10k ops, random valid/ready gaps -> invariant holds, no lost/dup results.

Source files
------------

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// seq_divider - iterative radix-2 restoring unsigned divider, one quotient bit/clk
// Revision 1.0
// ============================================================================
module seq_divider #(
   parameter int WIDTH_N = 10,
   parameter int WIDTH_D = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH_N-1:0] dividend,
   input  logic [WIDTH_D-1:0] divisor,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH_N-1:0] quotient,
   output logic [WIDTH_D-1:0] remainder,
   output logic               div_by_zero
);

   localparam int CW = $clog2(WIDTH_N + 1);
   localparam logic [CW-1:0] c_count_init = CW'(WIDTH_N);
   localparam logic [CW-1:0] c_count_one  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [WIDTH_N-1:0] r_shift;
   logic [WIDTH_D-1:0] r_pr;
   logic [WIDTH_D-1:0] r_divisor;
   logic [CW-1:0]      r_count;
   logic [WIDTH_N-1:0] r_quotient;
   logic [WIDTH_D-1:0] r_remainder;
   logic               r_dbz;

   logic               w_accept;
   logic               w_last;
   logic [WIDTH_D:0]   w_pr_shift;
   logic               w_ge;
   logic [WIDTH_D-1:0] w_pr_sub;
   logic [WIDTH_D-1:0] w_pr_next;
   logic [WIDTH_N-1:0] w_shift_next;

   // Trial value is WIDTH_D+1 bits; the stored remainder always fits WIDTH_D because it
   // stays below the divisor, so the subtraction only needs its low WIDTH_D bits.
   assign w_pr_shift   = {r_pr, r_shift[WIDTH_N-1]};
   assign w_ge         = (w_pr_shift >= {1'b0, r_divisor});
   assign w_pr_sub     = w_pr_shift[WIDTH_D-1:0] - r_divisor;
   assign w_pr_next    = w_ge ? w_pr_sub : w_pr_shift[WIDTH_D-1:0];
   assign w_shift_next = {r_shift[WIDTH_N-2:0], w_ge};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept     = 1'b1;
               w_state_next = (divisor == '0) ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            if (r_count == c_count_one) begin
               w_last       = 1'b1;
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift     <= '0;
         r_pr        <= '0;
         r_divisor   <= '0;
         r_count     <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else if (w_accept) begin
         if (divisor == '0) begin
            r_quotient  <= '1;
            r_remainder <= dividend[WIDTH_D-1:0];
            r_dbz       <= 1'b1;
         end else begin
            r_shift   <= dividend;
            r_pr      <= '0;
            r_divisor <= divisor;
            r_count   <= c_count_init;
         end
      end else if (r_state == S_BUSY) begin
         r_shift <= w_shift_next;
         r_pr    <= w_pr_next;
         r_count <= r_count - c_count_one;
         if (w_last) begin
            r_quotient  <= w_shift_next;
            r_remainder <= w_pr_next;
            r_dbz       <= 1'b0;
         end
      end
   end

   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// tb_seq_divider - directed and small randomised checks for seq_divider
// Revision 1.0
// ============================================================================
module tb_seq_divider;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [9:0] dividend = '0;
   logic [5:0] divisor = '0;
   logic       in_ready;
   logic       out_valid;
   logic [9:0] quotient;
   logic [5:0] remainder;
   logic       div_by_zero;

   int n_tests = 0;
   int n_fail  = 0;

   seq_divider #(.WIDTH_N(10), .WIDTH_D(6)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One complete transaction; hold = cycles of backpressure, poke = pulse in_valid meanwhile.
   task automatic run_op(input logic [9:0] a, input logic [5:0] b, input int hold,
                         input bit poke, input string tag);
      int         lat;
      logic [9:0] eq;
      logic [5:0] er;
      logic       edbz;
      int         elat;
      if (b == 6'd0) begin
         eq = '1; er = a[5:0]; edbz = 1'b1; elat = 0;
      end else begin
         eq = a / 10'(b); er = 6'(a % 10'(b)); edbz = 1'b0; elat = 10;
      end
      @(negedge clk);
      lat = 0;
      while (!in_ready && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      dividend  = a;
      divisor   = b;
      out_ready = (hold == 0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(elat));
      chk({tag, " quotient"}, 32'(quotient), 32'(eq));
      chk({tag, " remainder"}, 32'(remainder), 32'(er));
      chk({tag, " dbz"}, 32'(div_by_zero), 32'(edbz));
      for (int i = 0; i < hold; i++) begin
         if (poke) begin
            in_valid = ~in_valid;
            dividend = 10'd33;
            divisor  = 6'd5;
         end
         @(negedge clk);
         chk({tag, " hold valid"}, 32'(out_valid), 32'd1);
         chk({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
         chk({tag, " hold q"}, 32'(quotient), 32'(eq));
         chk({tag, " hold r"}, 32'(remainder), 32'(er));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk({tag, " post valid"}, 32'(out_valid), 32'd0);
      chk({tag, " post in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, " post q kept"}, 32'(quotient), 32'(eq));
      out_ready = 1'b0;
   endtask

   initial begin
      int seen;
      logic [9:0] ra;
      logic [5:0] rb;
      #2;
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst quotient", 32'(quotient), 32'd0);
      chk("rst remainder", 32'(remainder), 32'd0);
      chk("rst dbz", 32'(div_by_zero), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op(10'd100, 6'd7, 0, 1'b0, "100/7");
      run_op(10'd1023, 6'd1, 0, 1'b0, "1023/1");
      run_op(10'd5, 6'd63, 0, 1'b0, "5/63");
      run_op(10'd500, 6'd0, 0, 1'b0, "500/0");
      run_op(10'd9, 6'd3, 0, 1'b0, "9/3");
      run_op(10'd100, 6'd7, 5, 1'b1, "bp 100/7");
      run_op(10'd0, 6'd0, 2, 1'b0, "0/0");
      run_op(10'd63, 6'd63, 0, 1'b0, "63/63");

      // Abort an operation after four iterations.
      @(negedge clk);
      in_valid = 1'b1; dividend = 10'd200; divisor = 6'd9; out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst in_ready", 32'(in_ready), 32'd1);
      chk("midrst quotient", 32'(quotient), 32'd0);
      chk("midrst remainder", 32'(remainder), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("midrst no result", 32'(seen), 32'd0);
      out_ready = 1'b0;
      run_op(10'd77, 6'd6, 0, 1'b0, "77/6");

      for (int k = 0; k < 200; k++) begin
         ra = 10'($urandom_range(0, 1023));
         rb = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_op(ra, rb, int'($urandom_range(0, 2)), 1'b0, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", n_tests, n_fail);
      $fatal(1);
   end

endmodule
`default_nettype wire
